// File: rtl/uart_cmd_pkg.sv
// Shared constants, status codes and FSM encoding for the UART command responder.
package uart_cmd_pkg;

    localparam logic [7:0] SOF_REQ = 8'hA5;
    localparam logic [7:0] SOF_RSP = 8'h5A;
    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_CHK  = 8'h01;
    localparam logic [7:0] ST_BAD_CMD  = 8'h02;
    localparam logic [7:0] ST_BAD_ADDR = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_FETCH,
        S_EXEC,
        S_SEND
    } state_t;

    // Response frame byte at position tidx: SOF, STAT, RDATA, RCHK.
    function automatic logic [7:0] resp_byte(input logic [1:0] tidx,
                                             input logic [7:0] stat,
                                             input logic [7:0] rdata);
        case (tidx)
            2'd0:    return SOF_RSP;
            2'd1:    return stat;
            2'd2:    return rdata;
            default: return stat ^ rdata;
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// NUM_REGS x 8 register file: one synchronous write port, one combinational read port.
module uart_cmd_regfile #(
    parameter int NUM_REGS = 8,
    parameter int AW       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [7:0]            wdata,
    input  logic [AW-1:0]         raddr,
    output logic [7:0]            rdata,
    output logic [NUM_REGS*8-1:0] regs_flat
);

    logic [NUM_REGS-1:0][7:0] mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    mem <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    // Non-power-of-two depths leave unused address codes; read those as zero.
    assign rdata     = ({1'b0, raddr} < (AW+1)'(NUM_REGS)) ? mem[raddr] : 8'h00;
    assign regs_flat = mem;

endmodule

// File: rtl/uart_cmd_responder.sv
// Pops A5-framed commands from the RX FIFO, executes them on the register file, pushes 5A responses.
// Optional TIMEOUT_EN: abandons a partial frame after TIMEOUT_CYCLES idle cycles in FETCH.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int NUM_REGS       = 8,
    parameter int TIMEOUT_CYCLES = 520833
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_fifo_empty,
    input  logic [7:0]            rx_data,
    output logic                  rx_rd_en,
    input  logic                  tx_fifo_full,
    output logic [7:0]            tx_data,
    output logic                  tx_wr_en,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] tidx_q, tidx_d;
    logic       busy_q, busy_d;
    logic [7:0] cmd_q, addr_q, data_q, chk_q;
    logic [7:0] stat_q, rdata_q;
    logic [7:0] stat, rd_val;
    logic       we;

`ifdef TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        tmo_hit;
    assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   tmo_q <= '0;
        else if (state_q == S_FETCH && rx_fifo_empty) tmo_q <= tmo_q + 32'd1;
        else                                        tmo_q <= '0;
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

    uart_cmd_regfile #(.NUM_REGS(NUM_REGS), .AW(AW)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (addr_q[AW-1:0]),
        .wdata     (data_q),
        .raddr     (addr_q[AW-1:0]),
        .rdata     (rd_val),
        .regs_flat (regs_flat)
    );

    // Status priority: checksum, then command, then address range.
    always_comb begin
        stat = ST_OK;
        if ((cmd_q ^ addr_q ^ data_q) != chk_q)          stat = ST_BAD_CHK;
        else if (cmd_q != CMD_WR && cmd_q != CMD_RD)     stat = ST_BAD_CMD;
        else if ({1'b0, addr_q} >= 9'(NUM_REGS))         stat = ST_BAD_ADDR;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tidx_d    = tidx_q;
        busy_d    = busy_q;
        rx_rd_en  = 1'b0;
        tx_wr_en  = 1'b0;
        tx_data   = 8'h00;
        frame_err = 1'b0;
        we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_fifo_empty) begin
                    rx_rd_en = 1'b1;
                    state_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (idx_q == 3'd0 && rx_data != SOF_REQ) begin
                    state_d = S_IDLE;
                end else begin
                    if (idx_q == 3'd0) busy_d = 1'b1;
                    if (idx_q < 3'd4) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_FETCH: begin
                if (!rx_fifo_empty) begin
                    rx_rd_en = 1'b1;
                    state_d  = S_CAPTURE;
                end
`ifdef TIMEOUT_EN
                else if (tmo_hit) begin
                    idx_d     = 3'd0;
                    busy_d    = 1'b0;
                    frame_err = 1'b1;
                    state_d   = S_IDLE;
                end
`endif
            end
            S_EXEC: begin
                frame_err = (stat != ST_OK);
                we        = (stat == ST_OK) && (cmd_q == CMD_WR);
                tidx_d    = 2'd0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                // Data is held on resp[tidx] while TX is full so the byte is stable when finally pushed.
                tx_data = resp_byte(tidx_q, stat_q, rdata_q);
                if (!tx_fifo_full) begin
                    tx_wr_en = 1'b1;
                    tidx_d   = tidx_q + 2'd1;
                    if (tidx_q == 2'd3) begin
                        busy_d  = 1'b0;
                        idx_d   = 3'd0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            tidx_q  <= 2'd0;
            busy_q  <= 1'b0;
            cmd_q   <= 8'h00;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            chk_q   <= 8'h00;
            stat_q  <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tidx_q  <= tidx_d;
            busy_q  <= busy_d;
            if (state_q == S_CAPTURE) begin
                case (idx_q)
                    3'd1:    cmd_q  <= rx_data;
                    3'd2:    addr_q <= rx_data;
                    3'd3:    data_q <= rx_data;
                    3'd4:    chk_q  <= rx_data;
                    default: ;
                endcase
            end
            if (state_q == S_EXEC) begin
                stat_q  <= stat;
                rdata_q <= (stat != ST_OK) ? 8'h00 : (cmd_q == CMD_RD) ? rd_val : data_q;
            end
        end
    end

    assign busy = busy_q;

endmodule
